// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: display readout has strict priority, buffered
// host writes drain into idle cycles, and host reads follow all earlier writes.
module vram_arbiter #(
    parameter int unsigned ADDR_W     = 13,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdoReq,
    input  logic [ADDR_W-1:0] rdoAddr,
    output logic [DATA_W-1:0] rdoData,
    output logic              rdoValid,
    input  logic              hostWrReq,
    input  logic [ADDR_W-1:0] hostWrAddr,
    input  logic [DATA_W-1:0] hostWrData,
    output logic              hostWrFull,
    input  logic              hostRdReq,
    input  logic [ADDR_W-1:0] hostRdAddr,
    output logic              hostRdBusy,
    output logic [DATA_W-1:0] hostRdData,
    output logic              hostRdDone,
    output logic [ADDR_W-1:0] memAddr,
    output logic [DATA_W-1:0] memWrData,
    output logic              memWe,
    input  logic [DATA_W-1:0] memRdData
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_entry_t;

    // Tag of the read issued last cycle; steers memRdData to its consumer.
    typedef enum logic [1:0] {
        GRANT_NONE,
        GRANT_RDO,
        GRANT_HRD
    } grant_t;

    grant_t            last_grant;
    grant_t            grant;
    logic              wr_go;

    wr_entry_t         fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              fifo_empty;
    logic              push;
    wr_entry_t         head;

    logic              rd_pend;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_done;
    logic              rd_accept;

    logic [ADDR_W-1:0] last_addr;
    logic [DATA_W-1:0] last_wdata;
    logic [DATA_W-1:0] rdo_hold;
    logic [DATA_W-1:0] hrd_hold;

    assign fifo_empty = (count == '0);
    assign hostWrFull = (count == CNT_W'(FIFO_DEPTH));
    assign push       = hostWrReq && !hostWrFull;
    assign head       = fifo_mem[rd_ptr];

    // A completing read frees the read slot in the same cycle it returns data.
    assign rd_done    = (last_grant == GRANT_HRD);
    assign hostRdBusy = rd_pend && !rd_done;
    assign rd_accept  = hostRdReq && !hostRdBusy;

    assign rdoValid   = (last_grant == GRANT_RDO);
    assign hostRdDone = rd_done;
    assign rdoData    = rdoValid ? memRdData : rdo_hold;
    assign hostRdData = rd_done ? memRdData : hrd_hold;

    // Grant state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= GRANT_NONE;
        end else begin
            last_grant <= grant;
        end
    end

    // Per-cycle grant: readout, then buffered writes, then the pending host read.
    always_comb begin
        grant     = GRANT_NONE;
        wr_go     = 1'b0;
        memWe     = 1'b0;
        memAddr   = last_addr;
        memWrData = last_wdata;
        if (!rst) begin
            if (rdoReq) begin
                grant   = GRANT_RDO;
                memAddr = rdoAddr;
            end else if (!fifo_empty) begin
                wr_go     = 1'b1;
                memWe     = 1'b1;
                memAddr   = head.addr;
                memWrData = head.data;
            end else if (hostRdBusy) begin
                grant   = GRANT_HRD;
                memAddr = rd_addr;
            end
        end
    end

    // Bus hold registers and returned-data holding registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_addr  <= '0;
            last_wdata <= '0;
            rdo_hold   <= '0;
            hrd_hold   <= '0;
        end else begin
            last_addr  <= memAddr;
            last_wdata <= memWrData;
            rdo_hold   <= rdoData;
            hrd_hold   <= hostRdData;
        end
    end

    // Write FIFO storage.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= '{addr: hostWrAddr, data: hostWrData};
        end
    end

    // Write FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (wr_go) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            unique case ({push, wr_go})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Host read request latch; a new request may overlap the done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_pend <= 1'b0;
            rd_addr <= '0;
        end else if (rd_accept) begin
            rd_pend <= 1'b1;
            rd_addr <= hostRdAddr;
        end else if (rd_done) begin
            rd_pend <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench for vram_arbiter with a behavioural registered VRAM.
module tb_vram_arbiter;

    localparam int unsigned AW = 13;
    localparam int unsigned DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          rdoReq;
    logic [AW-1:0] rdoAddr;
    logic [DW-1:0] rdoData;
    logic          rdoValid;
    logic          hostWrReq;
    logic [AW-1:0] hostWrAddr;
    logic [DW-1:0] hostWrData;
    logic          hostWrFull;
    logic          hostRdReq;
    logic [AW-1:0] hostRdAddr;
    logic          hostRdBusy;
    logic [DW-1:0] hostRdData;
    logic          hostRdDone;
    logic [AW-1:0] memAddr;
    logic [DW-1:0] memWrData;
    logic          memWe;
    logic [DW-1:0] memRdData = '0;

    logic [DW-1:0] vram [1 << AW];
    int            cyc = 0;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;

    exp_t wr_q[$];
    exp_t rdo_q[$];
    exp_t hrd_q[$];
    exp_t me;

    int n_vec = 0;
    int n_bad = 0;

    vram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .rdoReq     (rdoReq),
        .rdoAddr    (rdoAddr),
        .rdoData    (rdoData),
        .rdoValid   (rdoValid),
        .hostWrReq  (hostWrReq),
        .hostWrAddr (hostWrAddr),
        .hostWrData (hostWrData),
        .hostWrFull (hostWrFull),
        .hostRdReq  (hostRdReq),
        .hostRdAddr (hostRdAddr),
        .hostRdBusy (hostRdBusy),
        .hostRdData (hostRdData),
        .hostRdDone (hostRdDone),
        .memAddr    (memAddr),
        .memWrData  (memWrData),
        .memWe      (memWe),
        .memRdData  (memRdData)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // VRAM model: synchronous write, registered read with one cycle latency.
    always @(posedge clk) begin
        if (memWe) vram[memAddr] <= memWrData;
        memRdData <= vram[memAddr];
    end

    function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
        return DW'(32'(a) * 7 + 3);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares every DUT-presented transaction with the queue heads.
    always @(negedge clk) begin
        if (!rst && rdoReq) begin
            chk("rdo_we", 32'(memWe), 32'(0));
            chk("rdo_addr", 32'(memAddr), 32'(rdoAddr));
        end
        if (memWe) begin
            chk("wr_expected", 32'(wr_q.size() != 0), 32'(1));
            if (wr_q.size() != 0) begin
                me = wr_q.pop_front();
                chk("wr_addr", 32'(memAddr), 32'(me.addr));
                chk("wr_data", 32'(memWrData), 32'(me.data));
                chk("wr_cycle", 32'(cyc), 32'(me.cyc));
            end
        end
        if (rdoValid) begin
            chk("rdo_expected", 32'(rdo_q.size() != 0), 32'(1));
            if (rdo_q.size() != 0) begin
                me = rdo_q.pop_front();
                chk("rdo_data", 32'(rdoData), 32'(me.data));
                chk("rdo_cycle", 32'(cyc), 32'(me.cyc));
            end
        end
        if (hostRdDone) begin
            chk("hrd_expected", 32'(hrd_q.size() != 0), 32'(1));
            chk("hrd_busy_at_done", 32'(hostRdBusy), 32'(0));
            if (hrd_q.size() != 0) begin
                me = hrd_q.pop_front();
                chk("hrd_data", 32'(hostRdData), 32'(me.data));
                chk("hrd_cycle", 32'(cyc), 32'(me.cyc));
            end
        end
    end

    initial begin
        int base;
        for (int a = 0; a < (1 << AW); a++) vram[a] = pat(AW'(a));
        rst = 1'b1;
        rdoReq = 1'b0;     rdoAddr = '0;
        hostWrReq = 1'b0;  hostWrAddr = '0; hostWrData = '0;
        hostRdReq = 1'b0;  hostRdAddr = '0;
        repeat (3) step();

        // Reset state
        chk("rst_memWe", 32'(memWe), 32'(0));
        chk("rst_memAddr", 32'(memAddr), 32'(0));
        chk("rst_memWrData", 32'(memWrData), 32'(0));
        chk("rst_rdoValid", 32'(rdoValid), 32'(0));
        chk("rst_rdoData", 32'(rdoData), 32'(0));
        chk("rst_hostRdDone", 32'(hostRdDone), 32'(0));
        chk("rst_hostRdData", 32'(hostRdData), 32'(0));
        chk("rst_hostRdBusy", 32'(hostRdBusy), 32'(0));
        chk("rst_hostWrFull", 32'(hostWrFull), 32'(0));
        rst = 1'b0;
        step();

        // 1: single write retires the next cycle
        base = cyc;
        hostWrReq = 1'b1; hostWrAddr = 13'h0010; hostWrData = 8'hA5;
        wr_q.push_back('{13'h0010, 8'hA5, base + 1});
        step();
        hostWrReq = 1'b0;
        step();
        chk("t1_we_after_drain", 32'(memWe), 32'(0));
        chk("t1_full", 32'(hostWrFull), 32'(0));
        repeat (2) step();

        // 2: continuous readout holds off three writes until it drops
        base = cyc;
        for (int i = 0; i < 20; i++) begin
            rdoReq = 1'b1;
            rdoAddr = AW'(13'h0200 + i);
            rdo_q.push_back('{rdoAddr, pat(rdoAddr), cyc + 1});
            if (i >= 2 && i <= 4) begin
                hostWrReq = 1'b1;
                hostWrAddr = AW'(13'h0020 + i);
                hostWrData = DW'(8'h40 + i);
                wr_q.push_back('{hostWrAddr, hostWrData, base + 20 + (i - 2)});
            end else begin
                hostWrReq = 1'b0;
            end
            step();
        end
        rdoReq = 1'b0; hostWrReq = 1'b0;
        repeat (5) step();

        // 3: FIFO overflow drops the fifth write
        base = cyc;
        for (int i = 0; i < 10; i++) begin
            rdoReq = 1'b1;
            rdoAddr = 13'h0300;
            rdo_q.push_back('{rdoAddr, pat(rdoAddr), cyc + 1});
            if (i < 5) begin
                hostWrReq = 1'b1;
                hostWrAddr = AW'(13'h0050 + i);
                hostWrData = DW'(8'h90 + i);
                if (i < 4) wr_q.push_back('{hostWrAddr, hostWrData, base + 10 + i});
            end else begin
                hostWrReq = 1'b0;
            end
            if (i == 3) chk("t3_not_full_yet", 32'(hostWrFull), 32'(0));
            if (i == 4) chk("t3_full", 32'(hostWrFull), 32'(1));
            step();
        end
        rdoReq = 1'b0;
        repeat (6) step();
        chk("t3_full_cleared", 32'(hostWrFull), 32'(0));

        // 4: read after write returns the written value; read accepted during done
        base = cyc;
        hostWrReq = 1'b1; hostWrAddr = 13'h0100; hostWrData = 8'h3C;
        wr_q.push_back('{13'h0100, 8'h3C, base + 1});
        step();
        hostWrReq = 1'b0;
        hostRdReq = 1'b1; hostRdAddr = 13'h0100;
        hrd_q.push_back('{13'h0100, 8'h3C, base + 3});
        step();
        hostRdReq = 1'b0;
        chk("t4_busy_pending", 32'(hostRdBusy), 32'(1));
        step();
        chk("t4_busy_at_done", 32'(hostRdBusy), 32'(0));
        hostRdReq = 1'b1; hostRdAddr = 13'h0400;
        hrd_q.push_back('{13'h0400, pat(13'h0400), base + 5});
        step();
        hostRdReq = 1'b0;
        chk("t4_second_accepted", 32'(hostRdBusy), 32'(1));
        repeat (4) step();
        chk("t4_data_held", 32'(hostRdData), 32'(pat(13'h0400)));
        chk("t4_busy_idle", 32'(hostRdBusy), 32'(0));

        // 5: read waits for the readout idle slot; read while busy is ignored
        base = cyc;
        for (int k = 0; k < 24; k++) begin
            rdoReq = ((k % 8) != 7);
            rdoAddr = AW'(13'h0500 + k);
            if (rdoReq) rdo_q.push_back('{rdoAddr, pat(rdoAddr), cyc + 1});
            hostRdReq = 1'b0;
            if (k == 1) begin
                hostRdReq = 1'b1; hostRdAddr = 13'h0600;
                hrd_q.push_back('{13'h0600, pat(13'h0600), base + 8});
            end
            if (k == 3) begin
                chk("t5_busy", 32'(hostRdBusy), 32'(1));
                hostRdReq = 1'b1; hostRdAddr = 13'h0700;
            end
            step();
        end
        rdoReq = 1'b0; hostRdReq = 1'b0;
        repeat (4) step();

        // 6: reset discards queued writes and the pending read
        base = cyc;
        for (int i = 0; i < 4; i++) begin
            rdoReq = 1'b1;
            rdoAddr = AW'(13'h0900 + i);
            rdo_q.push_back('{rdoAddr, pat(rdoAddr), cyc + 1});
            hostWrReq = (i < 2);
            hostWrAddr = AW'(13'h0070 + i);
            hostWrData = DW'(8'hE0 + i);
            hostRdReq = (i == 2);
            hostRdAddr = 13'h0800;
            step();
        end
        rdoReq = 1'b0; hostWrReq = 1'b0; hostRdReq = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t6_full_after_rst", 32'(hostWrFull), 32'(0));
        chk("t6_busy_after_rst", 32'(hostRdBusy), 32'(0));
        repeat (8) step();

        chk("end_wr_q_empty", 32'(wr_q.size()), 32'(0));
        chk("end_rdo_q_empty", 32'(rdo_q.size()), 32'(0));
        chk("end_hrd_q_empty", 32'(hrd_q.size()), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
Arbitrates the single-port VRAM between display readout and the host interface. Readout gets strict priority, so pixel fetch timing is never disturbed. Host writes are buffered in a small FIFO and drained into cycles the readout leaves idle. Host reads are served in order after all earlier buffered writes, and return their data over a done-pulse handshake.

Parameters:
ADDR_W, 13, VRAM address width
DATA_W, 8, VRAM data width
FIFO_DEPTH, 4, host write FIFO entries (power of 2, >=2)

Ports:
clk  in  1  VGA dot clock
rst  in  1  synchronous reset, active-high
rdoReq  in  1  readout requests a VRAM read this cycle
rdoAddr  in  ADDR_W  readout address
rdoData  out  DATA_W  readout read data
rdoValid  out  1  rdoData valid (one cycle after granted rdoReq)
hostWrReq  in  1  host write strobe (one-cycle pulse)
hostWrAddr  in  ADDR_W  host write address
hostWrData  in  DATA_W  host write data
hostWrFull  out  1  write FIFO full; host must not strobe
hostRdReq  in  1  host read strobe (one-cycle pulse)
hostRdAddr  in  ADDR_W  host read address
hostRdBusy  out  1  host read pending
hostRdData  out  DATA_W  host read result, held until next read completes
hostRdDone  out  1  one-cycle pulse, hostRdData valid
memAddr  out  ADDR_W  VRAM address
memWrData  out  DATA_W  VRAM write data
memWe  out  1  VRAM write enable
memRdData  in  DATA_W  VRAM read data, registered, 1-cycle latency

Behaviour:
- Reset: FIFO empty; rd pending cleared. hostWrFull=0, hostRdBusy=0, hostRdDone=0, rdoValid=0, memWe=0. memAddr, memWrData, hostRdData and rdoData are all 0.
- Grant is combinational per cycle. Priority order:
  (1) rdoReq: memAddr=rdoAddr, memWe=0.
  (2) FIFO non-empty: memAddr/memWrData = FIFO head, memWe=1, pop.
  (3) rd pending and FIFO empty: memAddr=latched read address, memWe=0.
  (4) idle: memWe=0, memAddr holds its last value.
- A registered lastGrant tag (NONE/RDO/HRD) routes memRdData in the following cycle:
  - RDO: rdoData=memRdData, rdoValid=1.
  - HRD: hostRdData<=memRdData, hostRdDone=1, pending cleared (hostRdBusy falls in the same cycle).
- Readout latency: exactly 1 cycle, unconditionally.
- Host read latency:
  - Minimum 2 cycles from hostRdReq (latch cycle, then grant cycle, with data/done on the next).
  - Actual latency is unbounded while rdoReq is continuous or the FIFO stays non-empty.
- Write FIFO:
  - Push on hostWrReq && !hostWrFull.
  - A push while full is dropped; FIFO contents are unchanged.
  - A simultaneous push and pop in the same cycle keeps the count unchanged.
  - Pointers wrap modulo FIFO_DEPTH. hostWrFull is combinational from the count.
- Ordering:
  - A host read never passes a previously accepted write, since rule (3) requires an empty FIFO.
  - A write strobed in the same cycle as hostRdReq is treated as earlier than the read.
- hostRdReq while hostRdBusy: ignored; latched address unchanged.
- hostRdReq and a hostRdDone pulse in the same cycle: the new request is accepted.
- No write-to-read forwarding; the bypass is supplied by the ordering rule alone.
- rst asserted mid-operation:
  - Pending FIFO writes and any pending read are discarded.
  - lastGrant goes to NONE, so no rdoValid or hostRdDone pulse follows reset.

Test Plan:
1. After reset, single hostWrReq addr 0x0010 data 0xA5, rdoReq=0 -> next cycle memWe=1, memAddr=0x0010, memWrData=0xA5; FIFO empty afterwards.
2. rdoReq held high 20 cycles while 3 host writes are strobed -> memWe=0 for all 20 cycles; rdoValid=1 on each of cycles 2..21 with correct data; the 3 writes retire in order on cycles 21-23 after rdoReq drops.
3. 5 back-to-back writes with rdoReq=1 and FIFO_DEPTH=4 -> hostWrFull asserts after the 4th; the 5th is dropped; exactly 4 memWe pulses occur once rdoReq drops.
4. Write 0x3C to 0x0100, then hostRdReq 0x0100 one cycle later, rdoReq=0 -> write retires first; hostRdDone pulses with hostRdData=0x3C; hostRdBusy clears in the same cycle.
5. Readout pattern of 1 cycle idle per 8 with a host read pending -> read is granted in the first idle slot; hostRdDone pulses exactly one cycle later; rdoValid cadence unaffected.
6. rst asserted while 2 writes are queued and a read is pending -> no memWe after reset, no hostRdDone; hostWrFull=0 and hostRdBusy=0 on the cycle after rst.
